// File: rtl/jk_bank_ctrl.sv
// Command sequencer for an external bank of JK flops with active-low preset/clear.
// Drives J/K/S/R so the bank loads, clears, presets, toggles, counts or shifts.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpClear  = 3'd1;
  localparam logic [2:0] OpPreset = 3'd2;
  localparam logic [2:0] OpLoad   = 3'd3;
  localparam logic [2:0] OpUp     = 3'd4;
  localparam logic [2:0] OpDown   = 3'd5;
  localparam logic [2:0] OpShl    = 3'd6;
  localparam logic [2:0] OpToggle = 3'd7;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             multi_op;

  logic [WIDTH-1:0] up_jk, dn_jk, shl_j;

  assign multi_op = (cmd_op == OpUp) || (cmd_op == OpDown) || (cmd_op == OpShl);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    r_d     = r_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          cnt_d  = multi_op ? cmd_steps : CNT_W'(1);
          if (cmd_op == OpNop || (multi_op && cmd_steps == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StExec;
            s_d     = (cmd_op == OpPreset) ? '0 : '1;
            r_d     = (cmd_op == OpClear) ? '0 : '1;
          end
        end
      end
      StExec: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StDone;
          s_d     = '1;
          r_d     = '1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= StIdle;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      s_q     <= '1;
      r_q     <= '1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  // Ripple enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin : excite_count
    logic cu, cd;
    cu = 1'b1;
    cd = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_jk[i] = cu;
      dn_jk[i] = cd;
      cu       = cu & q_fb[i];
      cd       = cd & ~q_fb[i];
    end
  end

  always_comb begin
    shl_j[0] = data_q[0];
    for (int i = 1; i < WIDTH; i++) begin
      shl_j[i] = q_fb[i-1];
    end
  end

  always_comb begin
    j_o = '0;
    k_o = '0;
    if (state_q == StExec) begin
      unique case (op_q)
        OpLoad:   begin j_o = data_q; k_o = ~data_q; end
        OpToggle: begin j_o = data_q; k_o = data_q;  end
        OpUp:     begin j_o = up_jk;  k_o = up_jk;   end
        OpDown:   begin j_o = dn_jk;  k_o = dn_jk;   end
        OpShl:    begin j_o = shl_j;  k_o = ~shl_j;  end
        OpNop, OpClear, OpPreset: begin j_o = '0; k_o = '0; end
      endcase
    end
  end

  assign s_o       = s_q;
  assign r_o       = r_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule
